window_3x3_gen: RTL and testbench

- Streaming 3x3 neighbourhood generator; the producer side of the calc filter kernel.
- Accepts raster-order pixels, one per valid cycle, and buffers two previous lines in internal line memories.
- Presents a complete 3x3 window on d0_o..d8_o with a one-cycle done_o qualifier.
- Sits between the pixel source (image RAM reader / camera interface) and calc; outputs connect one-to-one to calc's d0_i..d8_i and done_i.

---
 rtl/window_3x3_gen_if.sv | 31 +++
 rtl/window_3x3_gen.sv | 111 +++++++++++
 tb/tb_window_3x3_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream / window bus between the pixel source, window_3x3_gen and calc.
// The slave side is the window generator; the master side feeds pixels and consumes windows.
interface window_3x3_gen_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] pixel_i;
   logic              valid_i;
   logic [DATA_W-1:0] d0_o;
   logic [DATA_W-1:0] d1_o;
   logic [DATA_W-1:0] d2_o;
   logic [DATA_W-1:0] d3_o;
   logic [DATA_W-1:0] d4_o;
   logic [DATA_W-1:0] d5_o;
   logic [DATA_W-1:0] d6_o;
   logic [DATA_W-1:0] d7_o;
   logic [DATA_W-1:0] d8_o;
   logic              done_o;
   logic              frame_done_o;

   modport master (
      output pixel_i, valid_i,
      input  d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o,
      input  done_o, frame_done_o
   );

   modport slave (
      input  pixel_i, valid_i,
      output d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o,
      output done_o, frame_done_o
   );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line memories plus a 3x3 shift window,
// emitting a qualified window one cycle after each pixel that completes one.
module window_3x3_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic             clk,
   input  logic             rst_n,
   window_3x3_gen_if.slave  bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0]  col_r;
   logic [COL_W-1:0]  col_nxt_s;
   logic [ROW_W-1:0]  row_r;
   logic [ROW_W-1:0]  row_nxt_s;
   logic [DATA_W-1:0] lb1_r [IMG_W];
   logic [DATA_W-1:0] lb2_r [IMG_W];
   logic [DATA_W-1:0] lb1_rd_s;
   logic [DATA_W-1:0] lb2_rd_s;
   logic [DATA_W-1:0] win_r [9];
   logic              done_r;
   logic              frame_done_r;
   logic              win_done_s;
   logic              last_pix_s;

   // Read-before-write: the current column's old contents feed the window this cycle.
   assign lb1_rd_s = lb1_r[col_r];
   assign lb2_rd_s = lb2_r[col_r];

   // Raster position advance and window/frame qualification for the current pixel.
   always_comb begin
      col_nxt_s  = col_r;
      row_nxt_s  = row_r;
      win_done_s = 1'b0;
      last_pix_s = 1'b0;
      if (bus.valid_i) begin
         win_done_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
         last_pix_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
         if (col_r == COL_LAST) begin
            col_nxt_s = '0;
            if (row_r == ROW_LAST) begin
               row_nxt_s = '0;
            end else begin
               row_nxt_s = row_r + ROW_W'(1);
            end
         end else begin
            col_nxt_s = col_r + COL_W'(1);
         end
      end else begin
         win_done_s = 1'b0;
         last_pix_s = 1'b0;
      end
   end

   // Line memories: contents are don't-care after reset, so they carry no reset.
   always_ff @(posedge clk) begin
      if (bus.valid_i) begin
         lb2_r[col_r] <= lb1_rd_s;
         lb1_r[col_r] <= bus.pixel_i;
      end
   end

   // Counters, window shift registers and output qualifiers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_r        <= '0;
         row_r        <= '0;
         done_r       <= 1'b0;
         frame_done_r <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            win_r[i] <= '0;
         end
      end else begin
         col_r        <= col_nxt_s;
         row_r        <= row_nxt_s;
         done_r       <= win_done_s;
         frame_done_r <= last_pix_s;
         if (bus.valid_i) begin
            // Shift left unconditionally; stale previous-row data is gone by column 2.
            win_r[0] <= win_r[1];
            win_r[1] <= win_r[2];
            win_r[2] <= lb2_rd_s;
            win_r[3] <= win_r[4];
            win_r[4] <= win_r[5];
            win_r[5] <= lb1_rd_s;
            win_r[6] <= win_r[7];
            win_r[7] <= win_r[8];
            win_r[8] <= bus.pixel_i;
         end
      end
   end

   assign bus.d0_o         = win_r[0];
   assign bus.d1_o         = win_r[1];
   assign bus.d2_o         = win_r[2];
   assign bus.d3_o         = win_r[3];
   assign bus.d4_o         = win_r[4];
   assign bus.d5_o         = win_r[5];
   assign bus.d6_o         = win_r[6];
   assign bus.d7_o         = win_r[7];
   assign bus.d8_o         = win_r[8];
   assign bus.done_o       = done_r;
   assign bus.frame_done_o = frame_done_r;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 4x4 image: stimulus pushes expected windows,
// a negedge monitor pops and compares whenever done_o is presented.
module tb_window_3x3_gen;
   localparam int DW = 8;

   typedef struct packed {
      logic [8:0][DW-1:0] d;
      logic               fd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   hand [4][9];
   logic v_q = 1'b0;
   logic r_q = 1'b0;
   logic prev_ok = 1'b0;
   logic [8:0][DW-1:0] prev_s;

   always #5 clk = ~clk;

   window_3x3_gen_if #(.DATA_W(DW)) bus ();

   window_3x3_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [8:0][DW-1:0] outs();
      logic [8:0][DW-1:0] o;
      o[0] = bus.d0_o; o[1] = bus.d1_o; o[2] = bus.d2_o;
      o[3] = bus.d3_o; o[4] = bus.d4_o; o[5] = bus.d5_o;
      o[6] = bus.d6_o; o[7] = bus.d7_o; o[8] = bus.d8_o;
      return o;
   endfunction

   function automatic void chk(string name, logic [79:0] act, logic [79:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endfunction

   task automatic send(input int v);
      bus.pixel_i = DW'(v);
      bus.valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Windows complete at frame indices 10, 11, 14, 15; expected = hand table + base.
   task automatic send_frame(input int base, input bit gap, input int npix);
      exp_t e;
      int   w;
      for (int idx = 0; idx < npix; idx++) begin
         w = (idx == 10) ? 0 : (idx == 11) ? 1 : (idx == 14) ? 2 : (idx == 15) ? 3 : -1;
         if (w >= 0) begin
            for (int k = 0; k < 9; k++) begin
               e.d[k] = DW'(hand[w][k] + base);
            end
            e.fd = (idx == 15);
            exp_q.push_back(e);
         end
         send(base + idx);
         if (gap) begin
            idle(1);
         end
      end
   endtask

   always @(posedge clk) begin
      v_q <= bus.valid_i;
      r_q <= rst_n;
   end

   // Monitor: compare presented windows, hold behaviour, and stray qualifiers.
   always @(negedge clk) begin
      exp_t e;
      if (bus.done_o === 1'b1) begin
         if (v_q !== 1'b1) begin
            chk("done_after_idle", 80'(bus.done_o), 80'(0));
         end
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 80'(bus.done_o), 80'(0));
         end else begin
            e = exp_q.pop_front();
            chk("window", 80'(outs()), 80'(e.d));
            chk("frame_done", 80'(bus.frame_done_o), 80'(e.fd));
         end
      end else if (bus.frame_done_o === 1'b1) begin
         chk("stray_frame_done", 80'(bus.frame_done_o), 80'(0));
      end
      if (v_q === 1'b0 && r_q === 1'b1 && prev_ok) begin
         chk("hold", 80'(outs()), 80'(prev_s));
      end
      prev_s  = outs();
      prev_ok = 1'b1;
   end

   initial begin
      hand[0] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      hand[1] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      hand[2] = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
      hand[3] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.pixel_i = '0;
      idle(2);
      chk("reset_window", 80'(outs()), 80'(0));
      chk("reset_done", 80'({bus.done_o, bus.frame_done_o}), 80'(0));
      rst_n = 1'b1;
      idle(1);

      send_frame(0, 1'b0, 16);
      idle(2);
      send_frame(0, 1'b1, 16);
      idle(2);
      send_frame(0, 1'b0, 16);
      send_frame(100, 1'b0, 16);
      idle(2);

      send_frame(0, 1'b0, 7);
      rst_n = 1'b0;
      idle(1);
      chk("midframe_reset_window", 80'(outs()), 80'(0));
      chk("midframe_reset_done", 80'({bus.done_o, bus.frame_done_o}), 80'(0));
      rst_n = 1'b1;
      send_frame(50, 1'b0, 16);
      idle(3);

      chk("queue_empty", 80'(exp_q.size()), 80'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
